// File: rtl/buzz_pkg.sv
// buzz_pkg: shared definitions for the buzzer scheduler.
//   - owner encoding driven on the `owner` port
//   - scheduler state enum
//   - per-owner beep pattern constants and the pattern decode function
package buzz_pkg;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_ALARM = 2'd1;
  localparam logic [1:0] OWN_TIMER = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RING = 1'b1
  } state_e;

  // The buzzer is silent when (phase & MASK) == OFF.
  // Alarm: silent on odd phases (1-on / 1-off).
  // Timer: silent when phase == 3 (3-on / 1-off).
  localparam logic [1:0] PAT_ALARM_MASK = 2'b01;
  localparam logic [1:0] PAT_ALARM_OFF  = 2'b01;
  localparam logic [1:0] PAT_TIMER_MASK = 2'b11;
  localparam logic [1:0] PAT_TIMER_OFF  = 2'b11;

  // Buzzer level for a given owner at ring phase (two LSBs of ring_cnt).
  function automatic logic beep_on(input logic [1:0] own, input logic [1:0] phase);
    logic on;
    case (own)
      OWN_ALARM: on = ((phase & PAT_ALARM_MASK) != PAT_ALARM_OFF);
      OWN_TIMER: on = ((phase & PAT_TIMER_MASK) != PAT_TIMER_OFF);
      default:   on = 1'b0;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/buzzer_scheduler_req_edge_latch.sv
// req_edge_latch: rising-edge detector with a sticky pending flag.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   req  - request level from the source block
//   clr  - clear the pending flag (only ever raised for the current owner)
//   pend - pending flag
// Because clr is only raised while this source owns the buzzer, giving clr
// priority over a same-cycle edge means an edge wins over clr only when the
// source is not the owner.
module req_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic clr,
  output logic pend
);

  logic prev_r;
  logic pend_r;
  logic rise_s;
  logic pend_n_s;

  // Next pending value: owner clear beats a new edge, otherwise edges set it.
  always_comb begin
    rise_s = req & ~prev_r;
    if (clr) begin
      pend_n_s = 1'b0;
    end else if (rise_s) begin
      pend_n_s = 1'b1;
    end else begin
      pend_n_s = pend_r;
    end
  end

  // Previous-level and pending registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      prev_r <= req;
      pend_r <= pend_n_s;
    end
  end

  assign pend = pend_r;

endmodule

// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler: shares one piezo buzzer between the alarm and the
// countdown timer with fixed priority (alarm first), per-owner beep
// patterns, acknowledge, limited alarm snooze, ring timeout and sticky
// missed-event flags.
// Ports:
//   clk, rst        - 1 Hz clock, synchronous active-high reset
//   alarm_req       - alarm request level
//   timer_req       - timer request level
//   ack, snooze     - one-cycle user pulses
//   buzzer          - registered buzzer drive
//   owner           - 0 none, 1 alarm, 2 timer
//   snooze_active   - snooze countdown running
//   snooze_left     - remaining snooze cycles
//   missed_alarm    - sticky: alarm ring timed out
//   missed_timer    - sticky: timer ring timed out
module buzzer_scheduler
  import buzz_pkg::*;
#(
  parameter int RING_CYCLES   = 60,
  parameter int SNOOZE_CYCLES = 300,
  parameter int MAX_SNOOZE    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_req,
  input  logic       timer_req,
  input  logic       ack,
  input  logic       snooze,
  output logic       buzzer,
  output logic [1:0] owner,
  output logic       snooze_active,
  output logic [8:0] snooze_left,
  output logic       missed_alarm,
  output logic       missed_timer
);

  localparam int RW = $clog2(RING_CYCLES) + 1;
  localparam int SW = $clog2(SNOOZE_CYCLES) + 1;
  localparam int UW = $clog2(MAX_SNOOZE + 1) + 1;

  state_e        state_r, state_n_s;
  logic [1:0]    owner_r, owner_n_s;
  logic [RW-1:0] ring_cnt_r, ring_cnt_n_s;
  logic          buzzer_r, buzzer_n_s;
  logic [SW-1:0] snz_left_r, snz_left_n_s;
  logic          snz_active_r, snz_active_n_s;
  logic          snz_pend_r, snz_pend_n_s;
  logic [UW-1:0] used_r, used_n_s;
  logic          missed_alarm_r, missed_alarm_n_s;
  logic          missed_timer_r, missed_timer_n_s;

  logic alarm_edge_pend_s, timer_pend_s, alarm_pend_s, other_pend_s;
  logic ringing_s, snz_ok_s, timeout_s, ring_end_s, idle_ack_s, expire_s;
  logic clr_alarm_s, clr_timer_s;

  req_edge_latch u_alarm_latch (
    .clk  (clk),
    .rst  (rst),
    .req  (alarm_req),
    .clr  (clr_alarm_s),
    .pend (alarm_edge_pend_s)
  );

  req_edge_latch u_timer_latch (
    .clk  (clk),
    .rst  (rst),
    .req  (timer_req),
    .clr  (clr_timer_s),
    .pend (timer_pend_s)
  );

  // Decode ring-ending events; ack beats snooze, and either beats timeout.
  always_comb begin
    ringing_s    = (state_r == RING);
    snz_ok_s     = ringing_s & snooze & ~ack & (owner_r == OWN_ALARM) &
                   (used_r < UW'(MAX_SNOOZE));
    timeout_s    = ringing_s & ~ack & ~snz_ok_s & (ring_cnt_r == RW'(RING_CYCLES - 1));
    ring_end_s   = ringing_s & (ack | snz_ok_s | timeout_s);
    idle_ack_s   = ~ringing_s & ack;
    clr_alarm_s  = ring_end_s & (owner_r == OWN_ALARM);
    clr_timer_s  = ring_end_s & (owner_r == OWN_TIMER);
    // Snooze expiry re-arms the alarm without needing a new request edge.
    alarm_pend_s = alarm_edge_pend_s | snz_pend_r;
    other_pend_s = (owner_r == OWN_ALARM) ? timer_pend_s : alarm_pend_s;
  end

  // Grant FSM: arbitration, hand-over without idle gap, and beep pattern.
  always_comb begin
    state_n_s    = state_r;
    owner_n_s    = owner_r;
    ring_cnt_n_s = ring_cnt_r;
    case (state_r)
      IDLE: begin
        ring_cnt_n_s = RW'(0);
        if (alarm_pend_s) begin
          state_n_s = RING;
          owner_n_s = OWN_ALARM;
        end else if (timer_pend_s) begin
          state_n_s = RING;
          owner_n_s = OWN_TIMER;
        end else begin
          state_n_s = IDLE;
          owner_n_s = OWN_NONE;
        end
      end
      RING: begin
        if (ring_end_s) begin
          ring_cnt_n_s = RW'(0);
          if (other_pend_s) begin
            state_n_s = RING;
            owner_n_s = (owner_r == OWN_ALARM) ? OWN_TIMER : OWN_ALARM;
          end else begin
            state_n_s = IDLE;
            owner_n_s = OWN_NONE;
          end
        end else begin
          // Timeout ends the ring at RING_CYCLES-1, so this never wraps.
          ring_cnt_n_s = ring_cnt_r + RW'(1);
        end
      end
      default: begin
        state_n_s    = IDLE;
        owner_n_s    = OWN_NONE;
        ring_cnt_n_s = RW'(0);
      end
    endcase
    if (state_n_s == RING) begin
      buzzer_n_s = beep_on(owner_n_s, 2'(ring_cnt_n_s));
    end else begin
      buzzer_n_s = 1'b0;
    end
  end

  // Snooze countdown, snooze budget and sticky missed flags.
  always_comb begin
    snz_left_n_s     = snz_left_r;
    snz_active_n_s   = snz_active_r;
    snz_pend_n_s     = snz_pend_r;
    used_n_s         = used_r;
    missed_alarm_n_s = missed_alarm_r;
    missed_timer_n_s = missed_timer_r;
    expire_s         = 1'b0;

    if (idle_ack_s) begin
      snz_left_n_s   = SW'(0);
      snz_active_n_s = 1'b0;
    end else if (snz_ok_s) begin
      snz_left_n_s   = SW'(SNOOZE_CYCLES);
      snz_active_n_s = 1'b1;
    end else if (snz_left_r != SW'(0)) begin
      snz_left_n_s = snz_left_r - SW'(1);
      if (snz_left_r == SW'(1)) begin
        snz_active_n_s = 1'b0;
        expire_s       = 1'b1;
      end else begin
        snz_active_n_s = snz_active_r;
      end
    end else begin
      snz_left_n_s = snz_left_r;
    end

    // An ending alarm ring drops any re-arm that lands in the same cycle.
    if (clr_alarm_s) begin
      snz_pend_n_s = 1'b0;
    end else if (expire_s) begin
      snz_pend_n_s = 1'b1;
    end else begin
      snz_pend_n_s = snz_pend_r;
    end

    if (clr_alarm_s) begin
      used_n_s = snz_ok_s ? (used_r + UW'(1)) : UW'(0);
    end else begin
      used_n_s = used_r;
    end

    if (idle_ack_s) begin
      missed_alarm_n_s = 1'b0;
      missed_timer_n_s = 1'b0;
    end else if (timeout_s) begin
      if (owner_r == OWN_ALARM) begin
        missed_alarm_n_s = 1'b1;
      end else begin
        missed_timer_n_s = 1'b1;
      end
    end else begin
      missed_alarm_n_s = missed_alarm_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      owner_r        <= OWN_NONE;
      ring_cnt_r     <= RW'(0);
      buzzer_r       <= 1'b0;
      snz_left_r     <= SW'(0);
      snz_active_r   <= 1'b0;
      snz_pend_r     <= 1'b0;
      used_r         <= UW'(0);
      missed_alarm_r <= 1'b0;
      missed_timer_r <= 1'b0;
    end else begin
      state_r        <= state_n_s;
      owner_r        <= owner_n_s;
      ring_cnt_r     <= ring_cnt_n_s;
      buzzer_r       <= buzzer_n_s;
      snz_left_r     <= snz_left_n_s;
      snz_active_r   <= snz_active_n_s;
      snz_pend_r     <= snz_pend_n_s;
      used_r         <= used_n_s;
      missed_alarm_r <= missed_alarm_n_s;
      missed_timer_r <= missed_timer_n_s;
    end
  end

  assign buzzer        = buzzer_r;
  assign owner         = owner_r;
  assign snooze_active = snz_active_r;
  assign snooze_left   = 9'(snz_left_r);
  assign missed_alarm  = missed_alarm_r;
  assign missed_timer  = missed_timer_r;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Testbench for buzzer_scheduler: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// behavioural model of the scheduling rules.
module tb_buzzer_scheduler;

  localparam int RC = 8;
  localparam int SC = 5;
  localparam int MS = 2;

  logic       clk;
  logic       rst;
  logic       alarm_req, timer_req, ack, snooze;
  logic       buzzer;
  logic [1:0] owner;
  logic       snooze_active;
  logic [8:0] snooze_left;
  logic       missed_alarm, missed_timer;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  // behavioural model state
  int m_owner, m_cnt, m_left, m_used;
  bit m_pa, m_pt, m_prev_a, m_prev_t, m_active, m_ma, m_mt, m_buz;

  buzzer_scheduler #(
    .RING_CYCLES   (RC),
    .SNOOZE_CYCLES (SC),
    .MAX_SNOOZE    (MS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alarm_req     (alarm_req),
    .timer_req     (timer_req),
    .ack           (ack),
    .snooze        (snooze),
    .buzzer        (buzzer),
    .owner         (owner),
    .snooze_active (snooze_active),
    .snooze_left   (snooze_left),
    .missed_alarm  (missed_alarm),
    .missed_timer  (missed_timer)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_cnt = 0; m_left = 0; m_used = 0;
    m_pa = 0; m_pt = 0; m_prev_a = 0; m_prev_t = 0;
    m_active = 0; m_ma = 0; m_mt = 0; m_buz = 0;
  endtask

  // One clock of the scheduling rules, written from the behaviour description.
  task automatic model_step(input bit a, input bit t, input bit ak, input bit sz);
    bit snz, to, fin, other, pa, pt;
    int n_owner, n_cnt;
    snz = 0; to = 0; fin = 0;
    pa = m_pa; pt = m_pt;
    n_owner = m_owner; n_cnt = m_cnt;
    if (m_owner != 0) begin
      snz = sz && !ak && m_owner == 1 && m_used < MS;
      to  = !ak && !snz && m_cnt == RC - 1;
      fin = ak || snz || to;
    end
    if (a && !m_prev_a) pa = 1;
    if (t && !m_prev_t) pt = 1;
    // snooze countdown
    if (m_owner == 0 && ak) begin
      m_left = 0; m_active = 0; m_ma = 0; m_mt = 0;
    end else if (snz) begin
      m_left = SC; m_active = 1;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_active = 0;
        pa = 1;
      end
    end
    if (fin) begin
      if (m_owner == 1) begin
        pa = 0;
        m_used = snz ? m_used + 1 : 0;
        if (to) m_ma = 1;
        other = m_pt;
      end else begin
        pt = 0;
        if (to) m_mt = 1;
        other = m_pa;
      end
      n_cnt = 0;
      n_owner = other ? 3 - m_owner : 0;
    end else if (m_owner != 0) begin
      n_cnt = m_cnt + 1;
    end else if (m_pa) begin
      n_owner = 1; n_cnt = 0;
    end else if (m_pt) begin
      n_owner = 2; n_cnt = 0;
    end
    m_owner = n_owner; m_cnt = n_cnt;
    m_pa = pa; m_pt = pt;
    m_prev_a = a; m_prev_t = t;
    if (m_owner == 1)      m_buz = (m_cnt % 2 == 0);
    else if (m_owner == 2) m_buz = (m_cnt % 4 != 3);
    else                   m_buz = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at negedge.
  task automatic cyc(input bit r, input bit a, input bit t, input bit ak, input bit sz);
    rst = r; alarm_req = a; timer_req = t; ack = ak; snooze = sz;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(a, t, ak, sz);
    @(negedge clk);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("buzzer",        32'(buzzer),        32'(m_buz));
      check("owner",         32'(owner),         32'(m_owner));
      check("snooze_active", 32'(snooze_active), 32'(m_active));
      check("snooze_left",   32'(snooze_left),   32'(m_left));
      check("missed_alarm",  32'(missed_alarm),  32'(m_ma));
      check("missed_timer",  32'(missed_timer),  32'(m_mt));
    end
  end

  initial begin
    logic [7:0] pat;
    bit a_lvl, t_lvl;
    model_reset();
    rst = 1'b1; alarm_req = 1'b0; timer_req = 1'b0; ack = 1'b0; snooze = 1'b0;

    // reset state
    cyc(1, 0, 0, 0, 0);
    cmp_en = 1;
    cyc(1, 0, 0, 0, 0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_buzzer", 32'(buzzer), 32'd0);
    check("rst_snooze_left", 32'(snooze_left), 32'd0);

    // 1: held alarm, alarm pattern for 8 cycles, timeout, no re-trigger
    cyc(0, 1, 0, 0, 0);
    check("t1_latency_owner", 32'(owner), 32'd0);
    pat = 8'b10101010;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 0);
      check("t1_alarm_pattern", 32'(buzzer), 32'(pat[7-i]));
    end
    cyc(0, 1, 0, 0, 0);
    check("t1_timeout_owner", 32'(owner), 32'd0);
    check("t1_missed_alarm", 32'(missed_alarm), 32'd1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
    check("t1_no_retrigger", 32'(owner), 32'd0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("t1_idle_ack_clears", 32'(missed_alarm), 32'd0);

    // 2: simultaneous rise, alarm first, ack hands over to timer
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    check("t2_alarm_first", 32'(owner), 32'd1);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    check("t2_owner_before_ack", 32'(owner), 32'd1);
    cyc(0, 1, 1, 1, 0);
    check("t2_owner_after_ack", 32'(owner), 32'd2);
    pat = 8'b11101110;
    check("t2_timer_pattern", 32'(buzzer), 32'(pat[7]));
    for (int i = 1; i < 8; i++) begin
      cyc(0, 1, 1, 0, 0);
      check("t2_timer_pattern", 32'(buzzer), 32'(pat[7-i]));
    end
    cyc(0, 1, 1, 0, 0);
    check("t2_missed_timer", 32'(missed_timer), 32'd1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);

    // 3: snooze twice, third ignored, ring times out
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    check("t3_snooze_load", 32'(snooze_left), 32'd5);
    check("t3_snooze_owner", 32'(owner), 32'd0);
    for (int i = 4; i >= 0; i--) begin
      cyc(0, 0, 0, 0, 0);
      check("t3_countdown", 32'(snooze_left), 32'(i));
    end
    check("t3_active_off", 32'(snooze_active), 32'd0);
    cyc(0, 0, 0, 0, 0);
    check("t3_rering", 32'(owner), 32'd1);
    cyc(0, 0, 0, 0, 1);
    check("t3_second_snooze", 32'(snooze_active), 32'd1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    check("t3_rering2", 32'(owner), 32'd1);
    cyc(0, 0, 0, 0, 1);
    check("t3_third_ignored", 32'(owner), 32'd1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0);
    check("t3_timeout", 32'(owner), 32'd0);
    check("t3_missed", 32'(missed_alarm), 32'd1);
    cyc(0, 0, 0, 1, 0);

    // 4: timer rings during snooze, alarm returns on expiry
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    check("t4_timer_rings", 32'(owner), 32'd2);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    check("t4_alarm_back", 32'(owner), 32'd1);
    cyc(0, 0, 0, 1, 0);

    // 5: ack and snooze together act as ack
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 1);
    check("t5_no_snooze", 32'(snooze_active), 32'd0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0);
    check("t5_no_rering", 32'(owner), 32'd0);

    // 6: reset mid-ring with snooze active and timer pending
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    check("t6_pre_owner", 32'(owner), 32'd1);
    check("t6_pre_active", 32'(snooze_active), 32'd1);
    cyc(1, 0, 0, 0, 0);
    check("t6_rst_buzzer", 32'(buzzer), 32'd0);
    check("t6_rst_owner", 32'(owner), 32'd0);
    check("t6_rst_left", 32'(snooze_left), 32'd0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0);
    check("t6_no_carryover", 32'(owner), 32'd0);

    // randomized traffic
    a_lvl = 0; t_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) a_lvl = ~a_lvl;
      if ($urandom_range(0, 9) == 0) t_lvl = ~t_lvl;
      cyc(($urandom_range(0, 299) == 0), a_lvl, t_lvl,
          ($urandom_range(0, 11) == 0), ($urandom_range(0, 5) == 0));
    end

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
